// File: rtl/neur_sched_pkg.sv
// Shared types and helpers for the neuron-core scheduler: FSM state encoding,
// default geometry and the small arithmetic helpers the top derives its sizes from.
package neur_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EV_RD,
        ST_EV_WR,
        ST_TS_RD,
        ST_TS_WR,
        ST_TR_RD,
        ST_TR_WR,
        ST_DONE
    } sched_state_e;

    localparam int DEF_TIME_STEP                 = 8;
    localparam int DEF_INPUT_NEURON              = 784;
    localparam int DEF_OUTPUT_NEURON             = 256;
    localparam int DEF_POST_NEUR_PARALLEL        = 4;
    localparam int DEF_AER_IN_WIDTH              = 12;
    localparam int DEF_PRE_NEUR_ADDR_WIDTH       = 10;
    localparam int DEF_POST_NEUR_ADDR_WIDTH      = 10;
    localparam int DEF_POST_NEUR_BYTE_ADDR_WIDTH = 2;
    localparam int DEF_SYN_ARRAY_ADDR_WIDTH      = 16;

    // Number of post-neuron SRAM words (POST_WORDS).
    function automatic int post_words(input int output_neuron, input int parallel);
        return output_neuron / parallel;
    endfunction

    // Bit index of the time-step marker flag in an AER word.
    function automatic int aer_marker_bit(input int aer_width);
        return aer_width - 1;
    endfunction

    // Length of the refractory sweep: it must cover both the pre counters and the post words.
    function automatic int sweep_len(input int pre_count, input int post_count);
        return (pre_count > post_count) ? pre_count : post_count;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// Word index counter shared by every sweep: load to zero, advance by one,
// and flag when the current index equals the sweep's last index.
module sweep_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] last_idx,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority so a new sweep always starts from word zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (advance) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == last_idx);

endmodule

// File: rtl/neuron_sched_ctrl.sv
// Neuron-core sequencer: consumes the AER input stream and runs the read-modify-write
// sweeps (input event, time step, refractory clear) over the post-neuron words and pre counters.
// Optional feature: define NEUR_SCHED_SPIKE_VEC_EN to export a registered copy of the
// core spike bits captured on every time-step write cycle.
module neuron_sched_ctrl
    import neur_sched_pkg::*;
#(
    parameter int TIME_STEP                 = DEF_TIME_STEP,
    parameter int INPUT_NEURON              = DEF_INPUT_NEURON,
    parameter int OUTPUT_NEURON             = DEF_OUTPUT_NEURON,
    parameter int POST_NEUR_PARALLEL        = DEF_POST_NEUR_PARALLEL,
    parameter int AER_IN_WIDTH              = DEF_AER_IN_WIDTH,
    parameter int PRE_NEUR_ADDR_WIDTH       = DEF_PRE_NEUR_ADDR_WIDTH,
    parameter int POST_NEUR_ADDR_WIDTH      = DEF_POST_NEUR_ADDR_WIDTH,
    parameter int POST_NEUR_BYTE_ADDR_WIDTH = DEF_POST_NEUR_BYTE_ADDR_WIDTH,
    parameter int SYN_ARRAY_ADDR_WIDTH      = DEF_SYN_ARRAY_ADDR_WIDTH
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 AER_IN_VALID,
    input  logic [AER_IN_WIDTH-1:0]              AER_IN_DATA,
    output logic                                 AER_IN_READY,
    input  logic                                 SPI_GATE_ACTIVITY_sync,
    input  logic [POST_NEUR_PARALLEL-1:0]        NEUR_EVENT_OUT,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]       CTRL_PRE_NEURON_ADDRESS,
    output logic [POST_NEUR_ADDR_WIDTH-1:0]      CTRL_POST_NEURON_ADDRESS,
    output logic                                 CTRL_PRE_NEUR_CS,
    output logic                                 CTRL_PRE_NEUR_WE,
    output logic                                 CTRL_POST_NEUR_CS,
    output logic                                 CTRL_POST_NEUR_WE,
    output logic                                 CTRL_SYNARRAY_CS,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0]      CTRL_SYNARRAY_ADDR,
    output logic                                 CTRL_NEUR_EVENT,
    output logic                                 CTRL_PRE_CNT_EN,
    output logic                                 CTRL_TSTEP_EVENT,
    output logic                                 CTRL_TREF_EVENT,
    output logic [$clog2(TIME_STEP)-1:0]         CURRENT_TIME_STEP,
    output logic                                 BUSY,
    output logic                                 SAMPLE_DONE
`ifdef NEUR_SCHED_SPIKE_VEC_EN
    ,
    output logic                                 SPIKE_VEC_VALID,
    output logic [POST_NEUR_PARALLEL-1:0]        SPIKE_VEC,
    output logic [$clog2(OUTPUT_NEURON/POST_NEUR_PARALLEL)-1:0] SPIKE_WORD_ADDR
`endif
);

    localparam int POST_WORDS  = post_words(OUTPUT_NEURON, POST_NEUR_PARALLEL);
    localparam int TR_WORDS    = sweep_len(INPUT_NEURON, POST_WORDS);
    localparam int W_WIDTH     = $clog2(TR_WORDS);
    localparam int POST_WORD_W = $clog2(POST_WORDS);
    localparam int STEP_W      = $clog2(TIME_STEP);
    localparam int MARKER_BIT  = aer_marker_bit(AER_IN_WIDTH);
    localparam int AER_ADDR_W  = AER_IN_WIDTH - 1;

    // The synapse address product is formed at SYN_ARRAY_ADDR_WIDTH, so it must not wrap.
    if (INPUT_NEURON * POST_WORDS > (1 << SYN_ARRAY_ADDR_WIDTH)) begin : g_syn_addr_check
        $error("neuron_sched_ctrl: INPUT_NEURON*POST_WORDS exceeds the synapse address space");
    end

    sched_state_e                   state_q;
    sched_state_e                   state_d;
    logic [STEP_W-1:0]              step_q;
    logic [STEP_W-1:0]              step_d;
    logic [PRE_NEUR_ADDR_WIDTH-1:0] pre_addr_q;
    logic [PRE_NEUR_ADDR_WIDTH-1:0] pre_addr_d;

    logic                   cnt_load;
    logic                   cnt_adv;
    logic [W_WIDTH-1:0]     cnt_last_idx;
    logic [W_WIDTH-1:0]     w_q;
    logic                   w_last;
    logic                   w_first;
    logic [POST_WORD_W-1:0] post_word;
    logic                   w_in_pre;
    logic                   w_in_post;

    logic                   aer_ready;
    logic                   aer_accept;
    logic [AER_ADDR_W-1:0]  aer_addr;

    logic [POST_NEUR_ADDR_WIDTH-1:0] post_addr_word;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] syn_addr_word;

    assign aer_ready  = (state_q == ST_IDLE) && !SPI_GATE_ACTIVITY_sync && !RST;
    assign aer_accept = aer_ready && AER_IN_VALID;
    assign aer_addr   = AER_IN_DATA[AER_ADDR_W-1:0];

    assign cnt_last_idx = ((state_q == ST_TR_RD) || (state_q == ST_TR_WR))
                        ? W_WIDTH'(TR_WORDS - 1) : W_WIDTH'(POST_WORDS - 1);

    sweep_counter #(
        .WIDTH(W_WIDTH)
    ) u_sweep_counter (
        .clk     (CLK),
        .rst     (RST),
        .load    (cnt_load),
        .advance (cnt_adv),
        .last_idx(cnt_last_idx),
        .count   (w_q),
        .last    (w_last)
    );

    assign w_first        = (w_q == '0);
    assign post_word      = w_q[POST_WORD_W-1:0];
    assign w_in_pre       = (32'(w_q) < 32'(INPUT_NEURON));
    assign w_in_post      = (32'(w_q) < 32'(POST_WORDS));
    assign post_addr_word = POST_NEUR_ADDR_WIDTH'({post_word, {POST_NEUR_BYTE_ADDR_WIDTH{1'b0}}});
    assign syn_addr_word  = SYN_ARRAY_ADDR_WIDTH'(SYN_ARRAY_ADDR_WIDTH'(pre_addr_q) * SYN_ARRAY_ADDR_WIDTH'(POST_WORDS)
                          + SYN_ARRAY_ADDR_WIDTH'(post_word));

    // Next-state logic: event dispatch in IDLE, two-cycle RMW per word, sweep exits.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        pre_addr_d = pre_addr_q;
        cnt_load   = 1'b0;
        cnt_adv    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aer_accept) begin
                    if (AER_IN_DATA[MARKER_BIT]) begin
                        state_d  = ST_TS_RD;
                        cnt_load = 1'b1;
                    end else if (32'(aer_addr) < 32'(INPUT_NEURON)) begin
                        state_d    = ST_EV_RD;
                        cnt_load   = 1'b1;
                        pre_addr_d = PRE_NEUR_ADDR_WIDTH'(aer_addr);
                    end
                end
            end
            ST_EV_RD: state_d = ST_EV_WR;
            ST_EV_WR: begin
                if (w_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EV_RD;
                    cnt_adv = 1'b1;
                end
            end
            ST_TS_RD: state_d = ST_TS_WR;
            ST_TS_WR: begin
                if (!w_last) begin
                    state_d = ST_TS_RD;
                    cnt_adv = 1'b1;
                end else if (step_q < STEP_W'(TIME_STEP - 1)) begin
                    state_d = ST_IDLE;
                    step_d  = step_q + STEP_W'(1);
                end else begin
                    state_d  = ST_TR_RD;
                    cnt_load = 1'b1;
                end
            end
            ST_TR_RD: state_d = ST_TR_WR;
            ST_TR_WR: begin
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_TR_RD;
                    cnt_adv = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, time-step and latched pre-neuron address registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            pre_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            pre_addr_q <= pre_addr_d;
        end
    end

    // Core control decode from state and word index; everything is held low during reset.
    always_comb begin
        CTRL_PRE_NEURON_ADDRESS  = '0;
        CTRL_POST_NEURON_ADDRESS = '0;
        CTRL_PRE_NEUR_CS         = 1'b0;
        CTRL_PRE_NEUR_WE         = 1'b0;
        CTRL_POST_NEUR_CS        = 1'b0;
        CTRL_POST_NEUR_WE        = 1'b0;
        CTRL_SYNARRAY_CS         = 1'b0;
        CTRL_SYNARRAY_ADDR       = '0;
        CTRL_NEUR_EVENT          = 1'b0;
        CTRL_PRE_CNT_EN          = 1'b0;
        CTRL_TSTEP_EVENT         = 1'b0;
        CTRL_TREF_EVENT          = 1'b0;
        CURRENT_TIME_STEP        = '0;
        BUSY                     = 1'b0;
        SAMPLE_DONE              = 1'b0;
        if (!RST) begin
            CURRENT_TIME_STEP = step_q;
            BUSY              = (state_q != ST_IDLE);
            case (state_q)
                ST_EV_RD, ST_EV_WR: begin
                    CTRL_POST_NEUR_CS        = 1'b1;
                    CTRL_POST_NEUR_WE        = (state_q == ST_EV_WR);
                    CTRL_POST_NEURON_ADDRESS = post_addr_word;
                    CTRL_SYNARRAY_CS         = (state_q == ST_EV_RD);
                    CTRL_SYNARRAY_ADDR       = syn_addr_word;
                    CTRL_NEUR_EVENT          = (state_q == ST_EV_WR);
                    if (w_first) begin
                        CTRL_PRE_NEUR_CS        = 1'b1;
                        CTRL_PRE_NEUR_WE        = (state_q == ST_EV_WR);
                        CTRL_PRE_CNT_EN         = (state_q == ST_EV_WR);
                        CTRL_PRE_NEURON_ADDRESS = pre_addr_q;
                    end
                end
                ST_TS_RD, ST_TS_WR: begin
                    CTRL_POST_NEUR_CS        = 1'b1;
                    CTRL_POST_NEUR_WE        = (state_q == ST_TS_WR);
                    CTRL_POST_NEURON_ADDRESS = post_addr_word;
                    CTRL_TSTEP_EVENT         = (state_q == ST_TS_WR);
                end
                ST_TR_RD, ST_TR_WR: begin
                    CTRL_TREF_EVENT = (state_q == ST_TR_WR);
                    if (w_in_pre) begin
                        CTRL_PRE_NEUR_CS        = 1'b1;
                        CTRL_PRE_NEUR_WE        = (state_q == ST_TR_WR);
                        CTRL_PRE_NEURON_ADDRESS = PRE_NEUR_ADDR_WIDTH'(w_q);
                    end
                    if (w_in_post) begin
                        CTRL_POST_NEUR_CS        = 1'b1;
                        CTRL_POST_NEUR_WE        = (state_q == ST_TR_WR);
                        CTRL_POST_NEURON_ADDRESS = post_addr_word;
                    end
                end
                ST_DONE: SAMPLE_DONE = 1'b1;
                default: ;
            endcase
        end
    end

    assign AER_IN_READY = aer_ready;

`ifdef NEUR_SCHED_SPIKE_VEC_EN
    logic                          spike_valid_q;
    logic                          spike_valid_d;
    logic [POST_NEUR_PARALLEL-1:0] spike_vec_q;
    logic [POST_NEUR_PARALLEL-1:0] spike_vec_d;
    logic [POST_WORD_W-1:0]        spike_addr_q;
    logic [POST_WORD_W-1:0]        spike_addr_d;

    // Capture the core spike bits and word index on every time-step write cycle.
    always_comb begin
        spike_valid_d = (state_q == ST_TS_WR);
        spike_vec_d   = spike_vec_q;
        spike_addr_d  = spike_addr_q;
        if (state_q == ST_TS_WR) begin
            spike_vec_d  = NEUR_EVENT_OUT;
            spike_addr_d = post_word;
        end
    end

    // Spike vector output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            spike_valid_q <= 1'b0;
            spike_vec_q   <= '0;
            spike_addr_q  <= '0;
        end else begin
            spike_valid_q <= spike_valid_d;
            spike_vec_q   <= spike_vec_d;
            spike_addr_q  <= spike_addr_d;
        end
    end

    assign SPIKE_VEC_VALID = spike_valid_q;
    assign SPIKE_VEC       = spike_vec_q;
    assign SPIKE_WORD_ADDR = spike_addr_q;
`else
    logic unused_neur_event;
    assign unused_neur_event = ^NEUR_EVENT_OUT;
`endif

endmodule

// File: tb/tb_neuron_sched_ctrl.sv
// Scoreboard bench for neuron_sched_ctrl: directed AER vectors push the expected per-cycle
// control pattern into a queue; a monitor pops and compares on every cycle with any strobe.
module tb_neuron_sched_ctrl;

    typedef struct packed {
        logic        pre_cs;
        logic        pre_we;
        logic [9:0]  pre_addr;
        logic        post_cs;
        logic        post_we;
        logic [9:0]  post_addr;
        logic        syn_cs;
        logic [15:0] syn_addr;
        logic        neur;
        logic        pre_cnt;
        logic        tstep;
        logic        tref;
        logic        done;
        logic [2:0]  step;
    } obs_t;

    typedef struct packed {
        logic [3:0] vec;
        logic [5:0] addr;
    } spike_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aer_in_valid = 1'b0;
    logic [11:0] aer_in_data = '0;
    logic        aer_in_ready;
    logic        spi_gate = 1'b0;
    logic [3:0]  neur_event_out;
    logic [9:0]  ctrl_pre_addr;
    logic [9:0]  ctrl_post_addr;
    logic        ctrl_pre_cs;
    logic        ctrl_pre_we;
    logic        ctrl_post_cs;
    logic        ctrl_post_we;
    logic        ctrl_syn_cs;
    logic [15:0] ctrl_syn_addr;
    logic        ctrl_neur_event;
    logic        ctrl_pre_cnt_en;
    logic        ctrl_tstep_event;
    logic        ctrl_tref_event;
    logic [2:0]  current_step;
    logic        busy;
    logic        sample_done;
`ifdef NEUR_SCHED_SPIKE_VEC_EN
    logic        spike_vec_valid;
    logic [3:0]  spike_vec;
    logic [5:0]  spike_word_addr;
`endif

    int     checks = 0;
    int     failures = 0;
    int     model_step = 0;
    obs_t   exp_q[$];
    spike_t spike_q[$];
    obs_t   mon_act;
    obs_t   mon_exp;
    spike_t spk_act;
    spike_t spk_exp;

    always #5 clk = ~clk;

    // Core model: spike bits depend on the addressed word; word 3 fires 4'b1010.
    assign neur_event_out = (ctrl_post_addr[9:2] == 8'd3) ? 4'b1010 : ctrl_post_addr[5:2];

    neuron_sched_ctrl dut (
        .CLK                     (clk),
        .RST                     (rst),
        .AER_IN_VALID            (aer_in_valid),
        .AER_IN_DATA             (aer_in_data),
        .AER_IN_READY            (aer_in_ready),
        .SPI_GATE_ACTIVITY_sync  (spi_gate),
        .NEUR_EVENT_OUT          (neur_event_out),
        .CTRL_PRE_NEURON_ADDRESS (ctrl_pre_addr),
        .CTRL_POST_NEURON_ADDRESS(ctrl_post_addr),
        .CTRL_PRE_NEUR_CS        (ctrl_pre_cs),
        .CTRL_PRE_NEUR_WE        (ctrl_pre_we),
        .CTRL_POST_NEUR_CS       (ctrl_post_cs),
        .CTRL_POST_NEUR_WE       (ctrl_post_we),
        .CTRL_SYNARRAY_CS        (ctrl_syn_cs),
        .CTRL_SYNARRAY_ADDR      (ctrl_syn_addr),
        .CTRL_NEUR_EVENT         (ctrl_neur_event),
        .CTRL_PRE_CNT_EN         (ctrl_pre_cnt_en),
        .CTRL_TSTEP_EVENT        (ctrl_tstep_event),
        .CTRL_TREF_EVENT         (ctrl_tref_event),
        .CURRENT_TIME_STEP       (current_step),
        .BUSY                    (busy),
        .SAMPLE_DONE             (sample_done)
`ifdef NEUR_SCHED_SPIKE_VEC_EN
        ,
        .SPIKE_VEC_VALID         (spike_vec_valid),
        .SPIKE_VEC               (spike_vec),
        .SPIKE_WORD_ADDR         (spike_word_addr)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Expected records for an input event (optionally only the first nrec cycles).
    task automatic push_event(input int addr, input int nrec);
        obs_t o;
        int   n = 0;
        for (int w = 0; w < 64; w++) begin
            o = '0;
            o.post_cs   = 1'b1;
            o.post_addr = 10'(w * 4);
            o.syn_cs    = 1'b1;
            o.syn_addr  = 16'(addr * 64 + w);
            o.step      = 3'(model_step);
            if (w == 0) begin
                o.pre_cs   = 1'b1;
                o.pre_addr = 10'(addr);
            end
            if (n < nrec) exp_q.push_back(o);
            n++;
            o.syn_cs   = 1'b0;
            o.syn_addr = '0;
            o.post_we  = 1'b1;
            o.neur     = 1'b1;
            if (w == 0) begin
                o.pre_we  = 1'b1;
                o.pre_cnt = 1'b1;
            end
            if (n < nrec) exp_q.push_back(o);
            n++;
        end
    endtask

    // Expected records (and spike captures) for a time-step sweep.
    task automatic push_tstep(input int s);
        obs_t   o;
        spike_t sp;
        for (int w = 0; w < 64; w++) begin
            o = '0;
            o.post_cs   = 1'b1;
            o.post_addr = 10'(w * 4);
            o.step      = 3'(s);
            exp_q.push_back(o);
            o.post_we = 1'b1;
            o.tstep   = 1'b1;
            exp_q.push_back(o);
            sp.vec  = (w == 3) ? 4'b1010 : 4'(w);
            sp.addr = 6'(w);
            spike_q.push_back(sp);
        end
    endtask

    // Expected records for the refractory sweep followed by the done pulse.
    task automatic push_tref();
        obs_t o;
        for (int w = 0; w < 784; w++) begin
            o = '0;
            o.pre_cs   = 1'b1;
            o.pre_addr = 10'(w);
            o.step     = 3'd7;
            if (w < 64) begin
                o.post_cs   = 1'b1;
                o.post_addr = 10'(w * 4);
            end
            exp_q.push_back(o);
            o.pre_we  = 1'b1;
            o.post_we = (w < 64);
            o.tref    = 1'b1;
            exp_q.push_back(o);
        end
        o = '0;
        o.done = 1'b1;
        exp_q.push_back(o);
    endtask

    // Present one AER word and hold it until the handshake completes.
    task automatic applyStimulus(input logic [11:0] data);
        int waited = 0;
        aer_in_valid = 1'b1;
        aer_in_data  = data;
        @(negedge clk);
        while (!aer_in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!aer_in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready_timeout actual=0 expected=1 data=%h", data);
        end
        @(posedge clk);
        #1;
        aer_in_valid = 1'b0;
    endtask

    // Count busy cycles until the FSM returns to idle, then confirm the scoreboard drained.
    task automatic wait_idle(input string name, input int max_cycles, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (busy && cycles < max_cycles) begin
            cycles++;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout actual=busy expected=idle", name);
        end
        #1;
        checkOutput({name, "_queue_left"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with any strobe must match the next expected record.
    always @(negedge clk) begin
        if (!rst) begin
            mon_act = '0;
            mon_act.pre_cs    = ctrl_pre_cs;
            mon_act.pre_we    = ctrl_pre_we;
            mon_act.pre_addr  = ctrl_pre_cs ? ctrl_pre_addr : '0;
            mon_act.post_cs   = ctrl_post_cs;
            mon_act.post_we   = ctrl_post_we;
            mon_act.post_addr = ctrl_post_cs ? ctrl_post_addr : '0;
            mon_act.syn_cs    = ctrl_syn_cs;
            mon_act.syn_addr  = ctrl_syn_cs ? ctrl_syn_addr : '0;
            mon_act.neur      = ctrl_neur_event;
            mon_act.pre_cnt   = ctrl_pre_cnt_en;
            mon_act.tstep     = ctrl_tstep_event;
            mon_act.tref      = ctrl_tref_event;
            mon_act.done      = sample_done;
            mon_act.step      = sample_done ? 3'd0 : current_step;
            if (mon_act.pre_cs | mon_act.pre_we | mon_act.post_cs | mon_act.post_we | mon_act.syn_cs |
                mon_act.neur | mon_act.pre_cnt | mon_act.tstep | mon_act.tref | mon_act.done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_strobe actual=%h expected=none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        failures++;
                        $display("[TB] FAIL ctrl_record actual=%h expected=%h", mon_act, mon_exp);
                    end
                end
            end
        end
    end

`ifdef NEUR_SCHED_SPIKE_VEC_EN
    // Spike monitor: each valid spike vector must match the next captured word.
    always @(negedge clk) begin
        if (!rst && spike_vec_valid) begin
            checks++;
            spk_act.vec  = spike_vec;
            spk_act.addr = spike_word_addr;
            if (spike_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_spike actual=%h expected=none", spk_act);
            end else begin
                spk_exp = spike_q.pop_front();
                if (spk_act !== spk_exp) begin
                    failures++;
                    $display("[TB] FAIL spike_vec actual=%h expected=%h", spk_act, spk_exp);
                end
            end
        end
    end
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("ready_in_reset", aer_in_ready, 0);
        checkOutput("busy_in_reset", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", aer_in_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_step", current_step, 0);
        checkOutput("reset_done", sample_done, 0);
        @(posedge clk);
        #1;

        // Input event at pre address 5
        model_step = 0;
        push_event(5, 128);
        applyStimulus(12'd5);
        checkOutput("ev_ready_fall", aer_in_ready, 0);
        checkOutput("ev_busy", busy, 1);
        wait_idle("ev5", 300, cyc);
        checkOutput("ev5_len", cyc, 128);
        checkOutput("ev5_busy_end", busy, 0);

        // Out-of-range event is accepted and dropped
        applyStimulus(12'd800);
        checkOutput("drop_ready", aer_in_ready, 1);
        checkOutput("drop_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("drop_busy_later", busy, 0);

        // Eight time-step markers; the last one runs the refractory sweep
        for (int s = 0; s < 8; s++) begin
            push_tstep(s);
            if (s == 7) push_tref();
            applyStimulus(12'h800);
            wait_idle("tstep", 2000, cyc);
            checkOutput("tstep_len", cyc, (s == 7) ? 1697 : 128);
            checkOutput("tstep_step", current_step, (s == 7) ? 0 : s + 1);
        end
        model_step = 0;

        // SPI gate blocks acceptance while idle
        spi_gate     = 1'b1;
        aer_in_valid = 1'b1;
        aer_in_data  = 12'd5;
        repeat (3) begin
            @(negedge clk);
            checkOutput("gate_ready", aer_in_ready, 0);
        end
        checkOutput("gate_busy", busy, 0);
        @(posedge clk);
        #1;
        aer_in_valid = 1'b0;
        spi_gate     = 1'b0;

        // Gate raised mid-sweep: sweep still completes
        push_event(7, 128);
        applyStimulus(12'd7);
        repeat (10) @(posedge clk);
        #1 spi_gate = 1'b1;
        wait_idle("gate_mid", 300, cyc);
        checkOutput("gate_mid_len", cyc + 10, 128);
        checkOutput("gate_mid_ready", aer_in_ready, 0);
        spi_gate = 1'b0;
        @(negedge clk);
        checkOutput("gate_release_ready", aer_in_ready, 1);
        @(posedge clk);
        #1;

        // Advance to step 1, then reset in the middle of an event sweep
        push_tstep(0);
        applyStimulus(12'h800);
        wait_idle("pre_rst_ts", 300, cyc);
        checkOutput("pre_rst_step", current_step, 1);
        model_step = 1;
        push_event(9, 40);
        applyStimulus(12'd9);
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_strobes",
                    {ctrl_pre_cs, ctrl_pre_we, ctrl_post_cs, ctrl_post_we, ctrl_syn_cs,
                     ctrl_neur_event, ctrl_pre_cnt_en, ctrl_tstep_event, ctrl_tref_event, sample_done}, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_step", current_step, 0);
        checkOutput("rst_mid_ready", aer_in_ready, 1);
        checkOutput("rst_mid_queue", exp_q.size(), 0);
        model_step = 0;
        @(posedge clk);
        #1;

        // READY must be low in a reset cycle even when idle
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_reset_cycle", aer_in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", aer_in_ready, 1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_queue", exp_q.size(), 0);
`ifdef NEUR_SCHED_SPIKE_VEC_EN
        checkOutput("final_spike_queue", spike_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
